// File: rtl/processador_if.sv
// processador_if: groups the opcode input with the registered result and status flags.
//   instr         : opcode driven each cycle (instruction memory / bench side)
//   result        : registered 8-bit result
//   zero_flag, carry_flag, overflow_flag, sign_flag, parity_flag : registered status flags
interface processador_if;
    logic [7:0] instr;
    logic [7:0] result;
    logic       zero_flag;
    logic       carry_flag;
    logic       overflow_flag;
    logic       sign_flag;
    logic       parity_flag;

    modport master (
        output instr,
        input  result, zero_flag, carry_flag, overflow_flag, sign_flag, parity_flag
    );

    modport slave (
        input  instr,
        output result, zero_flag, carry_flag, overflow_flag, sign_flag, parity_flag
    );
endinterface

// File: rtl/processador.sv
// processador: single-cycle 8-bit ALU core with an 8x8 register file, io latch and halt state.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of processador_if (instr in; result and five flags out)

// processador_regfile: 8x8 register file; entries 0 and 1 are the A/B operands.
//   clk, reset : clock and synchronous reset (clears every entry)
//   we0/wd0    : write port for regs[0];  we1/wd1 : write port for regs[1]
//   a, b       : current contents of regs[0] and regs[1]
module processador_regfile (
    input  logic       clk,
    input  logic       reset,
    input  logic       we0,
    input  logic [7:0] wd0,
    input  logic       we1,
    input  logic [7:0] wd1,
    output logic [7:0] a,
    output logic [7:0] b
);
    logic [7:0] regs [0:7];

    assign a = regs[0];
    assign b = regs[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else begin
            if (we0) regs[0] <= wd0;
            if (we1) regs[1] <= wd1;
        end
    end
endmodule

module processador (
    input  logic          clk,
    input  logic          reset,
    processador_if.slave  bus
);
    logic [7:0]  a, b;
    logic        we0, we1;
    logic [7:0]  result_q, result_d, io_q, io_d, res;
    logic [4:0]  flags_q, flags_d;
    logic        halted_q, halted_d, c, v, exec;
    logic [8:0]  sum, diff;
    logic [15:0] prod;

    processador_regfile regs (
        .clk(clk), .reset(reset),
        .we0(we0), .wd0(io_q),
        .we1(we1), .wd1(a),
        .a(a), .b(b)
    );

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = a * b;

    always_comb begin
        res      = result_q;
        c        = 1'b0;
        v        = 1'b0;
        we0      = 1'b0;
        we1      = 1'b0;
        io_d     = io_q;
        halted_d = halted_q;
        // Undefined opcodes and the halted state behave as NOP: nothing moves.
        exec     = !halted_q && (bus.instr <= 8'h14);
        if (exec) begin
            case (bus.instr)
                8'h00: begin res = sum[7:0]; c = sum[8]; v = (a[7] == b[7]) && (sum[7] != a[7]); end
                // diff[8] is the borrow, i.e. A < B unsigned.
                8'h01: begin res = diff[7:0]; c = diff[8]; v = (a[7] != b[7]) && (diff[7] != a[7]); end
                8'h02: begin res = prod[7:0]; c = |prod[15:8]; v = |prod[15:8]; end
                8'h03: begin res = (b == 8'h00) ? 8'h00 : a / b; c = (b == 8'h00); end
                8'h04: begin res = (b == 8'h00) ? 8'h00 : a % b; c = (b == 8'h00); end
                8'h05: res = a & b;
                8'h06: res = a | b;
                8'h07: res = a ^ b;
                8'h08: res = {7'd0, a > b};
                8'h09: res = {7'd0, a < b};
                8'h0A: res = {7'd0, a == b};
                8'h0B: res = {7'd0, a != b};
                8'h0C: begin res = a; we1 = 1'b1; end
                8'h0D: begin res = {a[6:0], 1'b0}; c = a[7]; end
                8'h0E: begin res = {1'b0, a[7:1]}; c = a[0]; end
                8'h0F: res = a & 8'hFE;
                8'h10: res = a & 8'h7F;
                8'h11: begin res = io_q; we0 = 1'b1; end
                8'h12: begin res = a; io_d = a; end
                8'h13: begin res = a; halted_d = 1'b1; end
                default: res = ~a;
            endcase
        end
        result_d = exec ? res : result_q;
        flags_d  = exec ? {~|res, c, v, res[7], ~^res} : flags_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= 8'h00;
            flags_q  <= 5'b0;
            io_q     <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            io_q     <= io_d;
            halted_q <= halted_d;
        end
    end

    assign bus.result        = result_q;
    assign bus.zero_flag     = flags_q[4];
    assign bus.carry_flag    = flags_q[3];
    assign bus.overflow_flag = flags_q[2];
    assign bus.sign_flag     = flags_q[1];
    assign bus.parity_flag   = flags_q[0];
endmodule

// File: tb/tb_processador.sv
// tb_processador: scoreboard bench for processador; flags are packed {zero,carry,overflow,sign,parity}.
module tb_processador;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        string      tag;
        logic [7:0] res;
        logic [4:0] flg;
    } exp_t;

    exp_t sb [$];

    processador_if bus ();
    processador dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {bus.zero_flag, bus.carry_flag, bus.overflow_flag, bus.sign_flag, bus.parity_flag};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] er, input logic [4:0] ef);
        exp_t e;
        dut.regs.regs[0] = a;
        dut.regs.regs[1] = b;
        bus.instr = op;
        e.tag = tag; e.res = er; e.flg = ef;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".res"}, bus.result, e.res);
        check({e.tag, ".flg"}, {3'd0, flags()}, {3'd0, e.flg});
    endtask

    initial begin
        reset = 1'b1;
        bus.instr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst.res", bus.result, 8'h00);
        check("rst.flg", {3'd0, flags()}, 8'h00);
        check("rst.r0", dut.regs.regs[0], 8'h00);
        reset = 1'b0;

        issue("add_ovf", 8'h7F, 8'h01, 8'h00, 8'h80, 5'b00110);
        issue("sub_eq",  8'h05, 8'h05, 8'h01, 8'h00, 5'b10001);
        issue("sub_brw", 8'h03, 8'h05, 8'h01, 8'hFE, 5'b01010);
        issue("sub_ovf", 8'h80, 8'h01, 8'h01, 8'h7F, 5'b00100);
        issue("mul_hi",  8'h10, 8'h10, 8'h02, 8'h00, 5'b11101);
        issue("div0",    8'h07, 8'h00, 8'h03, 8'h00, 5'b11001);
        issue("mod",     8'h07, 8'h02, 8'h04, 8'h01, 5'b00000);
        issue("and",     8'hF0, 8'h3C, 8'h05, 8'h30, 5'b00001);
        issue("shl",     8'h81, 8'h00, 8'h0D, 8'h02, 5'b01000);
        issue("shr",     8'h81, 8'h00, 8'h0E, 8'h40, 5'b01000);
        issue("not",     8'h0F, 8'h00, 8'h14, 8'hF0, 5'b00011);
        issue("lt",      8'h03, 8'h09, 8'h09, 8'h01, 5'b00000);
        issue("mov",     8'h33, 8'h00, 8'h0C, 8'h33, 5'b00001);
        check("mov.r1", dut.regs.regs[1], 8'h33);
        issue("out",     8'h5A, 8'h00, 8'h12, 8'h5A, 5'b00001);
        issue("in",      8'h00, 8'h00, 8'h11, 8'h5A, 5'b00001);
        check("in.r0", dut.regs.regs[0], 8'h5A);
        issue("nop",     8'h01, 8'h01, 8'hFF, 8'h5A, 5'b00001);
        issue("halt",    8'h11, 8'h00, 8'h13, 8'h11, 5'b00001);
        issue("halted",  8'h01, 8'h01, 8'h00, 8'h11, 5'b00001);

        reset = 1'b1;
        bus.instr = 8'h00;
        @(posedge clk);
        #1;
        check("rst2.res", bus.result, 8'h00);
        check("rst2.flg", {3'd0, flags()}, 8'h00);
        reset = 1'b0;
        issue("add_post", 8'h01, 8'h01, 8'h00, 8'h02, 5'b00000);

        check("sb.empty", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
